// File: rtl/l1_mem_responder.sv
// Direct-mapped, write-through, no-write-allocate L1 answering the CPU PStrobe/PReady port over a word-wide req/ack memory.
// Optional hit/miss counters are enabled by defining L1_MEM_STATS_EN.
module l1_mem_responder #(
    parameter int INDEX_BITS = 6,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PStrobe,
    input  logic [31:0] PAddr,
    input  logic [3:0]  PWe,
    input  logic [31:0] PWData,
    output logic        PReady,
    output logic [31:0] PRData,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
`ifdef L1_MEM_STATS_EN
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt,
`endif
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);
    localparam int OFFS     = $clog2(LINE_WORDS);
    localparam int TAG_BITS = 32 - INDEX_BITS - OFFS - 2;
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int DA_W     = INDEX_BITS + OFFS;
    localparam int BEAT_W   = (OFFS > 0) ? OFFS : 1;

    typedef enum logic [2:0] {IDLE, LOOKUP, REFILL, WRITE, RESP} state_t;

    state_t state_q, state_d;

    logic [29:0]         req_waddr;
    logic [3:0]          req_we;
    logic [31:0]         req_wdata;
    logic [BEAT_W-1:0]   beat_q;
    logic [LINES-1:0]    valid_q;
    logic [TAG_BITS-1:0] tag_mem [LINES];
    logic [31:0]         data_mem [LINES*LINE_WORDS];

    logic [TAG_BITS-1:0]   req_tag;
    logic [INDEX_BITS-1:0] req_idx;
    logic [DA_W-1:0]       req_da, refill_da;
    logic [BEAT_W-1:0]     beat_inc;
    logic [31:0]           line_base, cur_word, merged;
    logic                  hit, last_beat, is_write;
    logic                  unused;

    assign unused    = ^PAddr[1:0];
    assign req_tag   = req_waddr[29 -: TAG_BITS];
    assign req_idx   = req_waddr[DA_W-1 -: INDEX_BITS];
    assign req_da    = req_waddr[DA_W-1:0];
    assign line_base = {req_waddr[29:OFFS], {(OFFS+2){1'b0}}};
    assign cur_word  = data_mem[req_da];
    assign hit       = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
    assign is_write  = (req_we != 4'b0000);
    assign beat_inc  = beat_q + BEAT_W'(1);
    assign last_beat = (beat_q == BEAT_W'(LINE_WORDS - 1));

    if (OFFS > 0) begin : g_multi_word
        assign refill_da = {req_idx, beat_q[OFFS-1:0]};
    end else begin : g_single_word
        assign refill_da = req_idx;
    end

    always_comb begin
        merged = cur_word;
        for (int b = 0; b < 4; b++)
            if (req_we[b]) merged[8*b +: 8] = req_wdata[8*b +: 8];
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (PStrobe) state_d = LOOKUP;
            LOOKUP:  state_d = is_write ? WRITE : (hit ? RESP : REFILL);
            REFILL:  if (mem_ack && last_beat) state_d = RESP;
            WRITE:   if (mem_ack) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state and registered outputs use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            req_waddr <= '0;
            req_we    <= '0;
            req_wdata <= '0;
            beat_q    <= '0;
            valid_q   <= '0;
            PReady    <= 1'b0;
            PRData    <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
        end else begin
            state_q <= state_d;
            PReady  <= 1'b0;
            unique case (state_q)
                IDLE: if (PStrobe) begin
                    req_waddr <= PAddr[31:2];
                    req_we    <= PWe;
                    req_wdata <= PWData;
                end
                LOOKUP: begin
                    if (is_write) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= {req_waddr, 2'b00};
                        mem_be    <= req_we;
                        mem_wdata <= req_wdata;
                    end else if (hit) begin
                        PRData <= cur_word;
                        PReady <= 1'b1;
                    end else begin
                        // The victim line is invalid until its last beat lands.
                        valid_q[req_idx] <= 1'b0;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= line_base;
                        beat_q   <= '0;
                    end
                end
                REFILL: if (mem_ack) begin
                    if (last_beat) begin
                        mem_req          <= 1'b0;
                        valid_q[req_idx] <= 1'b1;
                        PRData           <= (req_da == refill_da) ? mem_rdata : cur_word;
                        PReady           <= 1'b1;
                        beat_q           <= '0;
                    end else begin
                        beat_q   <= beat_inc;
                        mem_addr <= line_base | (32'(beat_inc) << 2);
                    end
                end
                WRITE: if (mem_ack) begin
                    mem_req <= 1'b0;
                    PReady  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // NOTE: tag/data arrays carry no reset; the valid bits alone decide whether their contents mean anything.
    always_ff @(posedge clk) begin
        if (state_q == LOOKUP && is_write && hit)
            data_mem[req_da] <= merged;
        if (state_q == REFILL && mem_ack) begin
            data_mem[refill_da] <= mem_rdata;
            if (last_beat) tag_mem[req_idx] <= req_tag;
        end
    end

`ifdef L1_MEM_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state_q == LOOKUP) begin
            if (hit && hit_cnt != '1)         hit_cnt  <= hit_cnt + 32'd1;
            else if (!hit && miss_cnt != '1)  miss_cnt <= miss_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_l1_mem_responder.sv
// Directed bench for l1_mem_responder: a behavioural word memory with a one-cycle ack and a
// transaction log back each scenario's hand-computed expectations.
module tb_l1_mem_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic        PStrobe;
    logic [31:0] PAddr;
    logic [3:0]  PWe;
    logic [31:0] PWData;
    logic        PReady;
    logic [31:0] PRData;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
`ifdef L1_MEM_STATS_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] mem_model [logic [31:0]];
    logic [31:0] log_addr [$];
    logic [31:0] log_wd [$];
    logic [3:0]  log_be [$];
    logic        log_we [$];

    l1_mem_responder dut (
        .clk(clk), .rst(rst), .PStrobe(PStrobe), .PAddr(PAddr), .PWe(PWe), .PWData(PWData),
        .PReady(PReady), .PRData(PRData), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
`ifdef L1_MEM_STATS_EN
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
`endif
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_read(input logic [31:0] a);
        return mem_model.exists(a) ? mem_model[a] : {16'hD00D, a[15:0]};
    endfunction

    // Memory side: acts 1 time unit after each rising edge, grants one ack per request cycle.
    initial begin
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_ack || !mem_req) begin
                mem_ack = 1'b0;
            end else begin
                log_addr.push_back(mem_addr);
                log_we.push_back(mem_we);
                log_be.push_back(mem_be);
                log_wd.push_back(mem_wdata);
                if (mem_we) begin
                    logic [31:0] w;
                    w = model_read(mem_addr);
                    for (int b = 0; b < 4; b++)
                        if (mem_be[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
                    mem_model[mem_addr] = w;
                end else begin
                    mem_rdata = model_read(mem_addr);
                end
                mem_ack = 1'b1;
            end
        end
    end

    task automatic clear_log();
        log_addr.delete(); log_we.delete(); log_be.delete(); log_wd.delete();
    endtask

    task automatic do_req(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd,
                          output logic [31:0] rd, output int lat);
        @(negedge clk);
        PStrobe = 1'b1; PAddr = a; PWe = we; PWData = wd;
        lat = 0;
        @(posedge clk);
        do begin
            @(negedge clk);
            lat++;
        end while (!PReady && lat < 200);
        rd = PRData;
        PStrobe = 1'b0; PAddr = 32'hDEAD_BEEF; PWe = 4'hF; PWData = 32'hFFFF_FFFF;
        if (lat >= 200) begin
            checks++; errors++;
            $display("FAIL timeout addr=%h no PReady within %0d cycles", a, lat);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; PStrobe = 1'b0; PAddr = '0; PWe = '0; PWData = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({PReady, mem_req, mem_we, mem_be} !== 7'b0 || PRData !== 32'h0 ||
            mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%b rd=%h req=%b we=%b addr=%h be=%b wd=%h want all 0",
                     PReady, PRData, mem_req, mem_we, mem_addr, mem_be, mem_wdata);
        end
        rst = 1'b0;
    endtask

    task automatic test_read_miss();
        logic [31:0] rd; int lat;
        mem_model[32'h100] = 32'hA0; mem_model[32'h104] = 32'hA1;
        mem_model[32'h108] = 32'hA2; mem_model[32'h10C] = 32'hA3;
        clear_log();
        do_req(32'h100, 4'b0000, '0, rd, lat);
        checks++;
        if (rd !== 32'hA0) begin errors++; $display("FAIL miss_rdata got %h want %h", rd, 32'hA0); end
        checks++;
        if (lat != 9) begin errors++; $display("FAIL miss_latency got %0d want 9", lat); end
        checks++;
        if (log_addr.size() != 4) begin
            errors++; $display("FAIL miss_beats got %0d want 4", log_addr.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (log_addr[i] !== 32'h100 + 32'(4*i) || log_we[i] !== 1'b0) begin
                    errors++;
                    $display("FAIL miss_beat%0d got addr=%h we=%b want addr=%h we=0",
                             i, log_addr[i], log_we[i], 32'h100 + 32'(4*i));
                end
            end
        end
`ifdef L1_MEM_STATS_EN
        checks++;
        if (miss_cnt !== 32'd1) begin errors++; $display("FAIL miss_cnt got %0d want 1", miss_cnt); end
`endif
    endtask

    task automatic test_read_hit();
        logic [31:0] rd; int lat;
        clear_log();
        do_req(32'h104, 4'b0000, '0, rd, lat);
        checks++;
        if (rd !== 32'hA1) begin errors++; $display("FAIL hit_rdata got %h want %h", rd, 32'hA1); end
        checks++;
        if (lat != 2) begin errors++; $display("FAIL hit_latency got %0d want 2", lat); end
        checks++;
        if (log_addr.size() != 0) begin errors++; $display("FAIL hit_mem_traffic got %0d want 0", log_addr.size()); end
`ifdef L1_MEM_STATS_EN
        checks++;
        if (hit_cnt !== 32'd1) begin errors++; $display("FAIL hit_cnt got %0d want 1", hit_cnt); end
`endif
    endtask

    task automatic test_write_hit();
        logic [31:0] rd; int lat;
        clear_log();
        do_req(32'h106, 4'b1100, 32'hBEEF_0000, rd, lat);
        checks++;
        if (lat != 3) begin errors++; $display("FAIL wr_latency got %0d want 3", lat); end
        checks++;
        if (log_addr.size() != 1 || log_addr[0] !== 32'h104 || log_we[0] !== 1'b1 ||
            log_be[0] !== 4'b1100 || log_wd[0] !== 32'hBEEF_0000) begin
            errors++;
            $display("FAIL wr_mem_txn got n=%0d addr=%h we=%b be=%b wd=%h want n=1 104 1 1100 beef0000",
                     log_addr.size(), log_addr[0], log_we[0], log_be[0], log_wd[0]);
        end
        clear_log();
        do_req(32'h104, 4'b0000, '0, rd, lat);
        checks++;
        if (rd !== 32'hBEEF_00A1 || lat != 2 || log_addr.size() != 0) begin
            errors++;
            $display("FAIL wr_hit_readback got %h lat=%0d n=%0d want beef00a1 lat=2 n=0", rd, lat, log_addr.size());
        end
    endtask

    task automatic test_write_miss();
        logic [31:0] rd; int lat;
        clear_log();
        do_req(32'h2000, 4'b1111, 32'h1122_3344, rd, lat);
        checks++;
        if (log_addr.size() != 1 || log_we[0] !== 1'b1 || log_addr[0] !== 32'h2000) begin
            errors++;
            $display("FAIL wmiss_txn got n=%0d addr=%h we=%b want n=1 2000 1", log_addr.size(), log_addr[0], log_we[0]);
        end
        clear_log();
        do_req(32'h2000, 4'b0000, '0, rd, lat);
        checks++;
        if (rd !== 32'h1122_3344 || lat != 9 || log_addr.size() != 4 || log_addr[0] !== 32'h2000) begin
            errors++;
            $display("FAIL wmiss_no_allocate got %h lat=%0d n=%0d want 11223344 lat=9 n=4", rd, lat, log_addr.size());
        end
    endtask

    task automatic test_conflict();
        logic [31:0] rd; int lat;
        clear_log();
        do_req(32'h1100, 4'b0000, '0, rd, lat);
        checks++;
        if (rd !== 32'hD00D_1100 || log_addr.size() != 4 || log_addr[3] !== 32'h110C) begin
            errors++;
            $display("FAIL conflict_refill got %h n=%0d want d00d1100 n=4", rd, log_addr.size());
        end
        clear_log();
        do_req(32'h100, 4'b0000, '0, rd, lat);
        checks++;
        if (rd !== 32'hA0 || lat != 9 || log_addr.size() != 4) begin
            errors++;
            $display("FAIL conflict_evict got %h lat=%0d n=%0d want a0 lat=9 n=4", rd, lat, log_addr.size());
        end
    endtask

    task automatic test_reset_mid_refill();
        logic [31:0] rd; int lat; int guard;
        clear_log();
        @(negedge clk);
        PStrobe = 1'b1; PAddr = 32'h1100; PWe = 4'b0000; PWData = '0;
        guard = 0;
        while (log_addr.size() < 2 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (guard >= 100) begin errors++; $display("FAIL midrst_wait got %0d beats want 2", log_addr.size()); end
        @(negedge clk);
        rst = 1'b1; PStrobe = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0 || PReady !== 1'b0) begin
            errors++; $display("FAIL midrst_req got req=%b rdy=%b want 0 0", mem_req, PReady);
        end
        rst = 1'b0;
        clear_log();
        do_req(32'h100, 4'b0000, '0, rd, lat);
        checks++;
        if (rd !== 32'hA0 || lat != 9 || log_addr.size() != 4) begin
            errors++; $display("FAIL midrst_reread got %h lat=%0d n=%0d want a0 lat=9 n=4", rd, lat, log_addr.size());
        end
        clear_log();
        do_req(32'h1104, 4'b0000, '0, rd, lat);
        checks++;
        if (rd !== 32'hD00D_1104 || log_addr.size() != 4) begin
            errors++; $display("FAIL midrst_partial_line got %h n=%0d want d00d1104 n=4", rd, log_addr.size());
        end
    endtask

    initial begin
        test_reset();
        test_read_miss();
        test_read_hit();
        test_write_hit();
        test_write_miss();
        test_conflict();
        test_reset_mid_refill();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
